// File: rtl/waterlight_sequencer.sv
// Water-light LED pattern sequencer: mode/speed driven prescaler plus pattern FSM.
// Optional pattern-cycle interrupt enabled by defining WATERLIGHT_IRQ_EN.
`timescale 1ns/1ps
module waterlight_sequencer #(
  parameter int unsigned LED_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [7:0]       mode,
  input  logic [31:0]      speed,
  output logic [LED_W-1:0] led,
  output logic             step_pulse
`ifdef WATERLIGHT_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             wl_irq
`endif
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_FLASH = 3'd3,
    S_PP_L  = 3'd4,
    S_PP_R  = 3'd5
  } state_e;

  localparam logic [LED_W-1:0] PAT_LSB = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_MSB = {1'b1, {(LED_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [2:0]        mode_q;
  logic [31:0]       speed_q;
  logic              step_q, step_d;

  logic              mode_chg, speed_chg, paused, do_step;
  logic [LED_W-1:0]  adv_led;
  state_e            adv_state;

  // mode[6:3] carries no function here
  logic unused_mode;
  assign unused_mode = ^mode[6:3];

  function automatic state_e decode(input logic [2:0] m);
    case (m)
      3'd1:    return S_LEFT;
      3'd2:    return S_RIGHT;
      3'd3:    return S_FLASH;
      3'd4:    return S_PP_L;
      default: return S_OFF;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] init_pat(input state_e s);
    case (s)
      S_LEFT:  return PAT_LSB;
      S_RIGHT: return PAT_MSB;
      S_FLASH: return '1;
      S_PP_L:  return PAT_LSB;
      default: return '0;
    endcase
  endfunction

  assign mode_chg  = (mode[2:0] != mode_q);
  assign speed_chg = (speed != speed_q);
  assign paused    = mode[7];
  assign do_step   = !mode_chg && !speed_chg && !paused &&
                     (cnt_q == '0) && (state_q != S_OFF);

  always_comb begin
    adv_led   = led_q;
    adv_state = state_q;
    case (state_q)
      S_LEFT:  adv_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      S_RIGHT: adv_led = {led_q[0], led_q[LED_W-1:1]};
      S_FLASH: adv_led = ~led_q;
      S_PP_L: begin
        adv_led = led_q << 1;
        if ((led_q << 1) == PAT_MSB) adv_state = S_PP_R;
      end
      S_PP_R: begin
        adv_led = led_q >> 1;
        if ((led_q >> 1) == PAT_LSB) adv_state = S_PP_L;
      end
      default: ;
    endcase
  end

  // Priority: mode change, then speed change, then step/count.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (mode_chg) begin
      state_d = decode(mode[2:0]);
      led_d   = init_pat(decode(mode[2:0]));
      cnt_d   = speed;
    end else if (speed_chg) begin
      cnt_d = speed;
    end else if (do_step) begin
      state_d = adv_state;
      led_d   = adv_led;
      cnt_d   = speed;
      step_d  = 1'b1;
    end else if (!paused && cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_OFF;
      led_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      speed_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode[2:0];
      speed_q <= speed;
      step_q  <= step_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;

`ifdef WATERLIGHT_IRQ_EN
  logic irq_q, irq_d, irq_set;

  // A full cycle completes on the wrap/return step of each pattern
  always_comb begin
    irq_set = 1'b0;
    if (do_step) begin
      case (state_q)
        S_LEFT:  irq_set = (led_q == PAT_MSB);
        S_RIGHT: irq_set = (led_q == PAT_LSB);
        S_FLASH: irq_set = (led_q == '0);
        S_PP_R:  irq_set = ((led_q >> 1) == PAT_LSB);
        default: irq_set = 1'b0;
      endcase
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign wl_irq = irq_q;
`endif

endmodule

// File: tb/tb_waterlight_sequencer.sv
// Directed self-checking bench for waterlight_sequencer.
`timescale 1ns/1ps
module tb_waterlight_sequencer;

  logic        HCLK;
  logic        HRESETn;
  logic [7:0]  mode;
  logic [31:0] speed;
  logic [7:0]  led;
  logic        step_pulse;
`ifdef WATERLIGHT_IRQ_EN
  logic        irq_clr;
  logic        wl_irq;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  waterlight_sequencer #(.LED_W(8)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .mode       (mode),
    .speed      (speed),
    .led        (led),
    .step_pulse (step_pulse)
`ifdef WATERLIGHT_IRQ_EN
    ,
    .irq_clr    (irq_clr),
    .wl_irq     (wl_irq)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_led, input logic exp_step);
    check({tag, "_led"}, {24'd0, led}, {24'd0, exp_led});
    check({tag, "_step"}, {31'd0, step_pulse}, {31'd0, exp_step});
  endtask

  logic [7:0] exp;
  logic [7:0] pp_seq [15];

  initial begin
    pp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    HRESETn = 1'b0;
    mode    = 8'h00;
    speed   = 32'd0;
`ifdef WATERLIGHT_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) tick;
    check_out("reset", 8'h00, 1'b0);
    HRESETn = 1'b1;
    tick;
    check_out("idle", 8'h00, 1'b0);

    // left rotate, speed 3
    mode  = 8'h01;
    speed = 32'd3;
    tick;
    check_out("left_init", 8'h01, 1'b0);
    repeat (3) begin
      tick;
      check_out("left_wait", 8'h01, 1'b0);
    end
    tick;
    check_out("left_step1", 8'h02, 1'b1);
    exp = 8'h02;
    for (int i = 0; i < 7; i++) begin
      repeat (3) begin
        tick;
        check($sformatf("left_gap%0d", i), {31'd0, step_pulse}, 32'd0);
      end
      tick;
      exp = {exp[6:0], exp[7]};
      check_out($sformatf("left_step%0d", i + 2), exp, 1'b1);
    end
    check("left_wrap", {24'd0, led}, 32'h01);

    // pause: one count consumed, then frozen, resume without reload
    tick;
    mode = 8'h81;
    repeat (5) begin
      tick;
      check_out("pause", 8'h01, 1'b0);
    end
    mode = 8'h01;
    tick;
    tick;
    check_out("resume_wait", 8'h01, 1'b0);
    tick;
    check_out("resume_step", 8'h02, 1'b1);

    // speed 3 -> 9 mid-run
    tick;
    speed = 32'd9;
    tick;
    check_out("spd_reload", 8'h02, 1'b0);
    repeat (9) begin
      tick;
      check_out("spd_wait", 8'h02, 1'b0);
    end
    tick;
    check_out("spd_step", 8'h04, 1'b1);

    // rotate right
    mode = 8'h02;
    tick;
    check_out("right_init", 8'h80, 1'b0);
    repeat (9) begin
      tick;
      check_out("right_wait", 8'h80, 1'b0);
    end
    tick;
    check_out("right_step", 8'h40, 1'b1);

    // mode 6 decodes to off
    mode = 8'h06;
    tick;
    check_out("off_init", 8'h00, 1'b0);
    repeat (20) begin
      tick;
      check_out("off_hold", 8'h00, 1'b0);
    end

    // flash, speed 1
    mode  = 8'h03;
    speed = 32'd1;
    tick;
    check_out("flash_init", 8'hFF, 1'b0);
    tick;
    check_out("flash_wait", 8'hFF, 1'b0);
    tick;
    check_out("flash_s1", 8'h00, 1'b1);
    tick;
    check_out("flash_wait2", 8'h00, 1'b0);
    tick;
    check_out("flash_s2", 8'hFF, 1'b1);

    // ping-pong, speed 0
    mode  = 8'h04;
    speed = 32'd0;
    tick;
    check_out("pp_init", 8'h01, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick;
      check_out($sformatf("pp%0d", i), pp_seq[i], 1'b1);
    end

    // asynchronous reset mid-run
    mode = 8'h01;
    tick;
    check_out("pre_rst_init", 8'h01, 1'b0);
    tick;
    check_out("pre_rst_step", 8'h02, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 1'b0);
    repeat (3) begin
      tick;
      check_out("in_rst", 8'h00, 1'b0);
    end
    HRESETn = 1'b1;
    tick;
    check_out("post_rst_init", 8'h01, 1'b0);
    tick;
    check_out("post_rst_step", 8'h02, 1'b1);

`ifdef WATERLIGHT_IRQ_EN
    #2;
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
    check("irq_rst", {31'd0, wl_irq}, 32'd0);
    mode  = 8'h03;
    speed = 32'd1;
    tick;
    tick;
    tick;
    check_out("irq_flash0", 8'h00, 1'b1);
    check("irq_none", {31'd0, wl_irq}, 32'd0);
    tick;
    tick;
    check_out("irq_flashff", 8'hFF, 1'b1);
    check("irq_set", {31'd0, wl_irq}, 32'd1);
    irq_clr = 1'b1;
    tick;
    irq_clr = 1'b0;
    check("irq_clr", {31'd0, wl_irq}, 32'd0);
    tick;
    tick;
    irq_clr = 1'b1;
    tick;
    irq_clr = 1'b0;
    check_out("irq_flashff2", 8'hFF, 1'b1);
    check("irq_set_wins", {31'd0, wl_irq}, 32'd1);
    tick;
    check("irq_hold", {31'd0, wl_irq}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
